// File: rtl/split_carry_resolver_pkg.sv
// Shared definitions for the split-carry resolver: chunk geometry helpers
// and the resolver state encoding.
package split_carry_resolver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    function automatic int calc_ss(input int io);
        int lg;
        lg = $clog2(io);
        if ((lg >> 2) > 0) begin
            return 1 << (lg >> 2);
        end else begin
            return 1 << (lg >> 1);
        end
    endfunction

    function automatic int calc_n_parts(input int io, input int ss);
        return io / ss + (((io % ss) != 0) ? 1 : 0);
    endfunction

    function automatic int chunk_lo(input int j, input int ss);
        return j * ss;
    endfunction

    // The top chunk is clipped at io, so its carry lands at bit io.
    function automatic int chunk_hi(input int j, input int ss, input int io);
        int top;
        top = j * ss + ss;
        if (top > io) begin
            top = io;
        end else begin
            top = top;
        end
        return top - 1;
    endfunction

endpackage

// File: rtl/split_carry_round.sv
// One combinational carry-fold round: each chunk absorbs the carry coming out
// of the chunk below it; chunk 0 has no incoming carry and passes through.
module split_carry_round
    import split_carry_resolver_pkg::*;
#(
    parameter int IO      = 512,
    parameter int SS      = 4,
    parameter int N_PARTS = calc_n_parts(IO, SS)
) (
    input  logic [IO-1:0]      s,
    input  logic [N_PARTS-2:0] c,
    output logic [IO-1:0]      s_next,
    output logic [N_PARTS-1:0] c_next,
    output logic               top_carry
);

    localparam int HI0 = chunk_hi(0, SS, IO);
    localparam logic [N_PARTS-1:0] TOP_BIT = N_PARTS'(1) << (N_PARTS - 1);

    logic [N_PARTS-1:0] c_raw;

    assign s_next[HI0:0] = s[HI0:0];
    assign c_raw[0]      = 1'b0;

    for (genvar j = 1; j < N_PARTS; j++) begin : g_chunk
        localparam int LO = chunk_lo(j, SS);
        localparam int HI = chunk_hi(j, SS, IO);
        localparam int W1 = HI - LO + 2;
        assign {c_raw[j], s_next[HI:LO]} = {1'b0, s[HI:LO]} + W1'(c[j-1]);
    end

    assign top_carry = c_raw[N_PARTS-1];
    assign c_next    = c_raw & ~TOP_BIT;

endmodule

// File: rtl/split_carry_resolver.sv
// Resolves a split-adder redundant value (chunk sums + chunk carries) into a
// canonical binary sum, folding carries one chunk per cycle.
module split_carry_resolver
    import split_carry_resolver_pkg::*;
#(
    parameter  int IO      = 512,
    parameter  int SS      = calc_ss(IO),
    localparam int N_PARTS = calc_n_parts(IO, SS),
    localparam int RW      = $clog2(N_PARTS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IO-1:0]      in_sum,
    input  logic [N_PARTS-1:0] in_cout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IO-1:0]      out_sum,
    output logic               out_overflow,
    output logic [RW-1:0]      out_rounds
);

    localparam logic [N_PARTS-1:0] TOP_BIT = N_PARTS'(1) << (N_PARTS - 1);

    state_t             state_r;
    logic [IO-1:0]      sum_r;
    logic [N_PARTS-1:0] carry_r;
    logic               ovf_r;
    logic [RW-1:0]      rnd_r;

    logic [IO-1:0]      sum_next_s;
    logic [N_PARTS-1:0] carry_next_s;
    logic               top_carry_s;

    split_carry_round #(
        .IO      (IO),
        .SS      (SS),
        .N_PARTS (N_PARTS)
    ) u_round (
        .s         (sum_r),
        .c         (carry_r[N_PARTS-2:0]),
        .s_next    (sum_next_s),
        .c_next    (carry_next_s),
        .top_carry (top_carry_s)
    );

    assign in_ready = (state_r == ST_IDLE) && !rst;

    // Resolver FSM: capture, iterate carry folds, present result until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            sum_r        <= '0;
            carry_r      <= '0;
            ovf_r        <= 1'b0;
            rnd_r        <= '0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_overflow <= 1'b0;
            out_rounds   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        sum_r   <= in_sum;
                        carry_r <= in_cout & ~TOP_BIT;
                        ovf_r   <= in_cout[N_PARTS-1];
                        rnd_r   <= '0;
                        state_r <= ST_RESOLVE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RESOLVE: begin
                    if (carry_r == '0) begin
                        out_sum      <= sum_r;
                        out_overflow <= ovf_r;
                        out_rounds   <= rnd_r;
                        out_valid    <= 1'b1;
                        state_r      <= ST_DONE;
                    end else begin
                        sum_r   <= sum_next_s;
                        carry_r <= carry_next_s;
                        ovf_r   <= ovf_r | top_carry_s;
                        rnd_r   <= rnd_r + RW'(1);
                        state_r <= ST_RESOLVE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_split_carry_resolver.sv
// Self-checking bench: directed table on IO=16/SS=4, handshake corner cases,
// and random split-adder vectors on IO=16 and ragged IO=10.
module tb_split_carry_resolver;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, out_overflow16;
    logic [15:0] in_sum16, out_sum16;
    logic [3:0]  in_cout16;
    logic [2:0]  out_rounds16;

    logic        in_valid10, in_ready10, out_valid10, out_ready10, out_overflow10;
    logic [9:0]  in_sum10, out_sum10;
    logic [2:0]  in_cout10;
    logic [1:0]  out_rounds10;

    split_carry_resolver #(.IO(16), .SS(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .in_sum(in_sum16), .in_cout(in_cout16), .out_valid(out_valid16),
        .out_ready(out_ready16), .out_sum(out_sum16),
        .out_overflow(out_overflow16), .out_rounds(out_rounds16)
    );

    split_carry_resolver #(.IO(10), .SS(4)) dut10 (
        .clk(clk), .rst(rst), .in_valid(in_valid10), .in_ready(in_ready10),
        .in_sum(in_sum10), .in_cout(in_cout10), .out_valid(out_valid10),
        .out_ready(out_ready10), .out_sum(out_sum10),
        .out_overflow(out_overflow10), .out_rounds(out_rounds10)
    );

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [15:0] sum;
        logic [3:0]  cout;
        logic [16:0] exp_val;
        int          exp_rnd;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Split-adder reference: chunks add independently, cin only into chunk 0.
    task automatic split_add(input int io, input int ss, input logic [31:0] a, input logic [31:0] b,
                             input logic cin, output logic [31:0] s, output logic [31:0] c);
        int n, lo, w;
        logic [31:0] m, t;
        n = (io + ss - 1) / ss;
        s = 32'd0;
        c = 32'd0;
        for (int j = 0; j < n; j++) begin
            lo = j * ss;
            w  = (io - lo < ss) ? io - lo : ss;
            m  = (32'd1 << w) - 32'd1;
            t  = ((a >> lo) & m) + ((b >> lo) & m) + ((j == 0) ? {31'd0, cin} : 32'd0);
            s  = s | ((t & m) << lo);
            c[j] = t[w];
        end
    endtask

    // er < 0: only the round bound is checked; hold = cycles of backpressure.
    task automatic apply16(input string name, input logic [15:0] s, input logic [3:0] c,
                           input logic [16:0] exp_val, input int er, input int hold);
        int k;
        @(negedge clk);
        k = 0;
        while (!in_ready16 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_ready"}, {31'd0, in_ready16}, 32'd1);
        in_sum16   = s;
        in_cout16  = c;
        in_valid16 = 1'b1;
        @(negedge clk);
        in_valid16 = 1'b0;
        k = 0;
        while (!out_valid16 && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_valid"}, {31'd0, out_valid16}, 32'd1);
        chk({name, "_result"}, {15'd0, out_overflow16, out_sum16}, {15'd0, exp_val});
        if (er >= 0) begin
            chk({name, "_rounds"}, {29'd0, out_rounds16}, er);
            chk({name, "_latency"}, k, er + 1);
        end else begin
            chk({name, "_rnd_bound"}, {31'd0, out_rounds16 <= 3'd3}, 32'd1);
            chk({name, "_latency"}, k, out_rounds16 + 1);
        end
        for (int h = 0; h < hold; h++) begin
            in_valid16 = h[0];
            in_sum16   = 16'($urandom);
            in_cout16  = 4'($urandom);
            @(negedge clk);
            chk({name, "_hold_valid"}, {31'd0, out_valid16}, 32'd1);
            chk({name, "_hold_ready"}, {31'd0, in_ready16}, 32'd0);
            chk({name, "_hold_result"}, {15'd0, out_overflow16, out_sum16}, {15'd0, exp_val});
        end
        in_valid16  = 1'b0;
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;
        chk({name, "_drain_valid"}, {31'd0, out_valid16}, 32'd0);
        chk({name, "_drain_ready"}, {31'd0, in_ready16}, 32'd1);
    endtask

    task automatic apply10(input logic [9:0] s, input logic [2:0] c, input logic [10:0] exp_val);
        int k;
        @(negedge clk);
        chk("r10_ready", {31'd0, in_ready10}, 32'd1);
        in_sum10   = s;
        in_cout10  = c;
        in_valid10 = 1'b1;
        @(negedge clk);
        in_valid10 = 1'b0;
        k = 0;
        while (!out_valid10 && k < 7) begin
            @(negedge clk);
            k++;
        end
        chk("r10_valid", {31'd0, out_valid10}, 32'd1);
        chk("r10_result", {21'd0, out_overflow10, out_sum10}, {21'd0, exp_val});
        chk("r10_rnd_bound", {31'd0, out_rounds10 <= 2'd2}, 32'd1);
        out_ready10 = 1'b1;
        @(negedge clk);
        out_ready10 = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, s, c;
        logic        cin;
        logic [16:0] full16;
        logic [10:0] full10;

        tbl[0] = '{16'h1234, 4'b0000, 17'h01234, 0};
        tbl[1] = '{16'h0F0F, 4'b0001, 17'h00F1F, 1};
        tbl[2] = '{16'hFFF0, 4'b0001, 17'h10000, 3};
        tbl[3] = '{16'h0000, 4'b1000, 17'h10000, 0};
        tbl[4] = '{16'hFFFF, 4'b0000, 17'h0FFFF, 0};
        tbl[5] = '{16'h0FF0, 4'b0101, 17'h02000, 3};
        tbl[6] = '{16'h8421, 4'b0110, 17'h09521, 1};
        tbl[7] = '{16'hF000, 4'b0100, 17'h10000, 1};

        rst = 1'b1;
        in_valid16 = 1'b0; out_ready16 = 1'b0; in_sum16 = '0; in_cout16 = '0;
        in_valid10 = 1'b0; out_ready10 = 1'b0; in_sum10 = '0; in_cout10 = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, out_valid16}, 32'd0);
        chk("rst_ready", {31'd0, in_ready16}, 32'd0);
        chk("rst_outputs", {12'd0, out_rounds16, out_overflow16, out_sum16}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", {31'd0, in_ready16}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            apply16($sformatf("tbl%0d", i), tbl[i].sum, tbl[i].cout, tbl[i].exp_val, tbl[i].exp_rnd, 0);
        end

        // Backpressure on the full-ripple case, then a fresh operand must be taken.
        apply16("bp", 16'hFFF0, 4'b0001, 17'h10000, 3, 10);
        apply16("bp_next", 16'h1234, 4'b0000, 17'h01234, 0, 0);

        // Reset while resolving the full-ripple case.
        apply16("pre_rst", 16'h8421, 4'b0110, 17'h09521, 1, 0);
        @(negedge clk);
        in_sum16 = 16'hFFF0; in_cout16 = 4'b0001; in_valid16 = 1'b1;
        @(negedge clk);
        in_valid16 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, out_valid16}, 32'd0);
        chk("midrst_outputs", {12'd0, out_rounds16, out_overflow16, out_sum16}, 32'd0);
        chk("midrst_ready", {31'd0, in_ready16}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_release_ready", {31'd0, in_ready16}, 32'd1);
        chk("midrst_release_valid", {31'd0, out_valid16}, 32'd0);
        apply16("post_rst", 16'hFFF0, 4'b0001, 17'h10000, 3, 0);

        for (int i = 0; i < 200; i++) begin
            a = $urandom & 32'hFFFF;
            b = $urandom & 32'hFFFF;
            cin = 1'($urandom);
            split_add(16, 4, a, b, cin, s, c);
            full16 = 17'(a + b + {31'd0, cin});
            apply16("rand16", s[15:0], c[3:0], full16, -1, 0);
        end

        for (int i = 0; i < 1000; i++) begin
            a = $urandom & 32'h3FF;
            b = $urandom & 32'h3FF;
            cin = 1'($urandom);
            split_add(10, 4, a, b, cin, s, c);
            full10 = 11'(a + b + {31'd0, cin});
            apply10(s[9:0], c[2:0], full10);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
